// File: rtl/hdc_sram_load_ctrl_if.sv
// Host-side write stream into the HDC SRAM load controller.
// One beat carries a target SRAM index, an entry address and one hypervector.
interface hdc_sram_load_ctrl_if #(
  parameter int ADDR_WIDTH   = 7,
  parameter int HV_DIMENSION = 2000
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [3:0]              cfg_target;
  logic [ADDR_WIDTH-1:0]   cfg_addr;
  logic [HV_DIMENSION-1:0] cfg_hvin;

  modport master (output cfg_valid, cfg_target, cfg_addr, cfg_hvin, input cfg_ready);
  modport slave  (input cfg_valid, cfg_target, cfg_addr, cfg_hvin, output cfg_ready);
endinterface

// File: rtl/hdc_sram_load_ctrl.sv
// Steers host beats into the nine item/projection SRAMs, enforcing per-target
// ascending, exactly-once fill; infer_enable rises once every SRAM is full.
//   state   | meaning
//   S_IDLE  | after reset, waiting for load_start
//   S_LOAD  | accepting beats
//   S_DONE  | all nine SRAMs written, inference enabled
//   S_ERROR | load aborted, error_code held until load_start
module hdc_sram_load_ctrl #(
  parameter int GSR_NUM_CHANNEL = 32,
  parameter int ECG_NUM_CHANNEL = 77,
  parameter int EEG_NUM_CHANNEL = 105,
  parameter int HV_DIMENSION    = 2000,
  parameter int ADDR_WIDTH      = 7,
  parameter int GSR_ADDR_WIDTH  = 5,
  parameter int ECG_ADDR_WIDTH  = 7,
  parameter int EEG_ADDR_WIDTH  = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load_start,
  hdc_sram_load_ctrl_if.slave       i_cfg,
  output logic [2:0]                o_gsr_we,
  output logic [2:0]                o_ecg_we,
  output logic [2:0]                o_eeg_we,
  output logic [GSR_ADDR_WIDTH-1:0] o_gsr_addr,
  output logic [ECG_ADDR_WIDTH-1:0] o_ecg_addr,
  output logic [EEG_ADDR_WIDTH-1:0] o_eeg_addr,
  output logic [HV_DIMENSION-1:0]   o_gsr_hvin,
  output logic [HV_DIMENSION-1:0]   o_ecg_hvin,
  output logic [HV_DIMENSION-1:0]   o_eeg_hvin,
  output logic                      o_load_done,
  output logic                      o_load_error,
  output logic [1:0]                o_error_code,
  output logic                      o_infer_enable
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] N_GSR = CW'(GSR_NUM_CHANNEL);
  localparam logic [CW-1:0] N_ECG = CW'(ECG_NUM_CHANNEL);
  localparam logic [CW-1:0] N_EEG = CW'(EEG_NUM_CHANNEL);
  localparam logic [CW-1:0] CHAN [9] = '{N_GSR, N_GSR, N_GSR,
                                        N_ECG, N_ECG, N_ECG,
                                        N_EEG, N_EEG, N_EEG};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0]           r_cnt [9];
  logic [1:0]              r_err_code;
  logic [2:0]              r_gsr_we, r_ecg_we, r_eeg_we;
  logic [GSR_ADDR_WIDTH-1:0] r_gsr_addr;
  logic [ECG_ADDR_WIDTH-1:0] r_ecg_addr;
  logic [EEG_ADDR_WIDTH-1:0] r_eeg_addr;
  logic [HV_DIMENSION-1:0] r_gsr_hvin, r_ecg_hvin, r_eeg_hvin;

  logic          w_accept, w_bad_target, w_full, w_out_of_order;
  logic          w_write, w_error, w_all_full;
  logic [CW-1:0] w_cnt_sel, w_chan_sel;
  logic [8:0]    w_hit;
  logic [1:0]    w_err_code;

  // A beat colliding with load_start is dropped before any check.
  always_comb begin
    w_accept     = i_cfg.cfg_valid && (r_state == S_LOAD) && !i_load_start;
    w_bad_target = i_cfg.cfg_target > 4'd8;
    w_cnt_sel    = '0;
    w_chan_sel   = '0;
    w_hit        = '0;
    for (int i = 0; i < 9; i++) begin
      if (i_cfg.cfg_target == 4'(i)) begin
        w_cnt_sel  = r_cnt[i];
        w_chan_sel = CHAN[i];
        w_hit[i]   = 1'b1;
      end
    end
    w_full         = (w_cnt_sel == w_chan_sel);
    w_out_of_order = ({1'b0, i_cfg.cfg_addr} != w_cnt_sel);
    w_write        = w_accept && !w_bad_target && !w_full && !w_out_of_order;
    w_error        = w_accept && !w_write;
    if (w_bad_target)  w_err_code = 2'd1;
    else if (w_full)   w_err_code = 2'd3;
    else               w_err_code = 2'd2;
    // Completion looks at the counters as they will be after this write.
    w_all_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if ((r_cnt[i] + CW'(w_write && w_hit[i])) != CHAN[i]) w_all_full = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_load_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (i_load_start)             w_state_nxt = S_LOAD;
        else if (w_error)             w_state_nxt = S_ERROR;
        else if (w_write && w_all_full) w_state_nxt = S_DONE;
      end
      S_DONE, S_ERROR: if (i_load_start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    i_cfg.cfg_ready = (r_state == S_LOAD);
    o_load_done     = (r_state == S_DONE);
    o_infer_enable  = (r_state == S_DONE);
    o_load_error    = (r_state == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_cnt[i] <= '0;
      r_err_code <= '0;
      r_gsr_we   <= '0;
      r_ecg_we   <= '0;
      r_eeg_we   <= '0;
      r_gsr_addr <= '0;
      r_ecg_addr <= '0;
      r_eeg_addr <= '0;
      r_gsr_hvin <= '0;
      r_ecg_hvin <= '0;
      r_eeg_hvin <= '0;
    end else begin
      r_gsr_we <= w_write ? w_hit[2:0] : 3'b000;
      r_ecg_we <= w_write ? w_hit[5:3] : 3'b000;
      r_eeg_we <= w_write ? w_hit[8:6] : 3'b000;
      if (i_load_start) begin
        for (int i = 0; i < 9; i++) r_cnt[i] <= '0;
        r_err_code <= '0;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (w_write && w_hit[i]) r_cnt[i] <= r_cnt[i] + CW'(1);
        end
        if (w_error) r_err_code <= w_err_code;
      end
      if (w_write && |w_hit[2:0]) begin
        r_gsr_addr <= i_cfg.cfg_addr[GSR_ADDR_WIDTH-1:0];
        r_gsr_hvin <= i_cfg.cfg_hvin;
      end
      if (w_write && |w_hit[5:3]) begin
        r_ecg_addr <= i_cfg.cfg_addr[ECG_ADDR_WIDTH-1:0];
        r_ecg_hvin <= i_cfg.cfg_hvin;
      end
      if (w_write && |w_hit[8:6]) begin
        r_eeg_addr <= i_cfg.cfg_addr[EEG_ADDR_WIDTH-1:0];
        r_eeg_hvin <= i_cfg.cfg_hvin;
      end
    end
  end

  assign o_gsr_we     = r_gsr_we;
  assign o_ecg_we     = r_ecg_we;
  assign o_eeg_we     = r_eeg_we;
  assign o_gsr_addr   = r_gsr_addr;
  assign o_ecg_addr   = r_ecg_addr;
  assign o_eeg_addr   = r_eeg_addr;
  assign o_gsr_hvin   = r_gsr_hvin;
  assign o_ecg_hvin   = r_ecg_hvin;
  assign o_eeg_hvin   = r_eeg_hvin;
  assign o_error_code = r_err_code;

endmodule

// File: tb/tb_hdc_sram_load_ctrl.sv
// Directed bench for hdc_sram_load_ctrl: full, interleaved, error and restart loads.
module tb_hdc_sram_load_ctrl;
  localparam int HV = 2000;
  localparam int AW = 7;
  localparam int NCH [9] = '{32, 32, 32, 77, 77, 77, 105, 105, 105};

  logic clk = 1'b0;
  logic rst, load_start;
  always #5 clk = ~clk;

  hdc_sram_load_ctrl_if #(.ADDR_WIDTH(AW), .HV_DIMENSION(HV)) cfg_if ();

  logic [2:0]    gsr_we, ecg_we, eeg_we;
  logic [4:0]    gsr_addr;
  logic [6:0]    ecg_addr, eeg_addr;
  logic [HV-1:0] gsr_hvin, ecg_hvin, eeg_hvin;
  logic          load_done, load_error, infer_enable;
  logic [1:0]    error_code;
  wire  [8:0]    we9 = {eeg_we, ecg_we, gsr_we};

  int n_cmp = 0;
  int n_err = 0;

  hdc_sram_load_ctrl dut (
    .clk(clk), .rst(rst), .i_load_start(load_start), .i_cfg(cfg_if),
    .o_gsr_we(gsr_we), .o_ecg_we(ecg_we), .o_eeg_we(eeg_we),
    .o_gsr_addr(gsr_addr), .o_ecg_addr(ecg_addr), .o_eeg_addr(eeg_addr),
    .o_gsr_hvin(gsr_hvin), .o_ecg_hvin(ecg_hvin), .o_eeg_hvin(eeg_hvin),
    .o_load_done(load_done), .o_load_error(load_error),
    .o_error_code(error_code), .o_infer_enable(infer_enable)
  );

  function automatic logic [HV-1:0] hv_of(input int t, input int a);
    logic [15:0] w;
    w = 16'(t * 256 + a) ^ 16'hA5C3;
    return {125{w}};
  endfunction

  function automatic logic [6:0] obs_addr(input int t);
    if (t < 3) return {2'b00, gsr_addr};
    else if (t < 6) return ecg_addr;
    else return eeg_addr;
  endfunction

  function automatic logic [HV-1:0] obs_hv(input int t);
    if (t < 3) return gsr_hvin;
    else if (t < 6) return ecg_hvin;
    else return eeg_hvin;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_if.cfg_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input int t, input int a);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_target = 4'(t);
    cfg_if.cfg_addr   = 7'(a);
    cfg_if.cfg_hvin   = hv_of(t, a);
    tick();
  endtask

  task automatic idle(input int n);
    cfg_if.cfg_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({we9, gsr_addr, ecg_addr, eeg_addr} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_we_addr: got we=%b ga=%0d ea=%0d xa=%0d, want all 0", we9, gsr_addr, ecg_addr, eeg_addr);
    end
    n_cmp++;
    if ({gsr_hvin, ecg_hvin, eeg_hvin} !== '0) begin
      n_err++;
      $display("FAIL reset_hvin: got nonzero hypervector outputs, want 0");
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({load_done, load_error, error_code, infer_enable, cfg_if.cfg_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got done=%b err=%b code=%0d inf=%b rdy=%b, want all 0",
               load_done, load_error, error_code, infer_enable, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_full_load();
    int k;
    k = 0;
    pulse_start();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_ready: got %b, want 1", cfg_if.cfg_ready);
    end
    for (int t = 0; t < 9; t++) begin
      for (int a = 0; a < NCH[t]; a++) begin
        send(t, a);
        n_cmp++;
        if (we9 !== 9'(1 << t) || obs_addr(t) !== 7'(a) || obs_hv(t) !== hv_of(t, a)) begin
          n_err++;
          $display("FAIL full_beat t=%0d a=%0d: got we=%b addr=%0d data_ok=%b, want we=%b addr=%0d data_ok=1",
                   t, a, we9, obs_addr(t), obs_hv(t) === hv_of(t, a), 9'(1 << t), a);
        end
        if (k == 640) begin
          n_cmp++;
          if (load_done !== 1'b0 || infer_enable !== 1'b0) begin
            n_err++;
            $display("FAIL full_early_done: got done=%b inf=%b after beat 641, want 0 0", load_done, infer_enable);
          end
        end
        k++;
      end
    end
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (load_done !== 1'b1 || infer_enable !== 1'b1 || cfg_if.cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_done: got done=%b inf=%b rdy=%b, want 1 1 0", load_done, infer_enable, cfg_if.cfg_ready);
    end
    idle(3);
    n_cmp++;
    if (load_done !== 1'b1 || cfg_if.cfg_ready !== 1'b0 || we9 !== 9'd0) begin
      n_err++;
      $display("FAIL full_hold: got done=%b rdy=%b we=%b, want 1 0 0", load_done, cfg_if.cfg_ready, we9);
    end
  endtask

  task automatic test_done_restart();
    pulse_start();
    n_cmp++;
    if (infer_enable !== 1'b0 || load_done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_restart: got inf=%b done=%b rdy=%b, want 0 0 1", infer_enable, load_done, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_interleaved();
    int nxt [9];
    int total, gap;
    for (int t = 0; t < 9; t++) nxt[t] = 0;
    total = 0;
    while (total < 642) begin
      for (int t = 0; t < 9; t++) begin
        if (nxt[t] < NCH[t]) begin
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            idle(gap);
            n_cmp++;
            if (we9 !== 9'd0) begin
              n_err++;
              $display("FAIL inter_gap: got we=%b during stall, want 0", we9);
            end
          end
          send(t, nxt[t]);
          n_cmp++;
          if (we9 !== 9'(1 << t) || obs_addr(t) !== 7'(nxt[t]) || obs_hv(t) !== hv_of(t, nxt[t])) begin
            n_err++;
            $display("FAIL inter_beat t=%0d a=%0d: got we=%b addr=%0d, want we=%b addr=%0d",
                     t, nxt[t], we9, obs_addr(t), 9'(1 << t), nxt[t]);
          end
          nxt[t]++;
          total++;
        end
      end
    end
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (load_done !== 1'b1 || infer_enable !== 1'b1 || load_error !== 1'b0) begin
      n_err++;
      $display("FAIL inter_done: got done=%b inf=%b err=%b, want 1 1 0", load_done, infer_enable, load_error);
    end
  endtask

  task automatic test_out_of_order();
    pulse_start();
    send(4, 0);
    n_cmp++;
    if (we9 !== 9'b000010000 || ecg_addr !== 7'd0) begin
      n_err++;
      $display("FAIL ooo_first: got we=%b addr=%0d, want we=000010000 addr=0", we9, ecg_addr);
    end
    send(4, 2);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (we9 !== 9'd0 || load_error !== 1'b1 || error_code !== 2'd2 || cfg_if.cfg_ready !== 1'b0 || infer_enable !== 1'b0) begin
      n_err++;
      $display("FAIL ooo_error: got we=%b err=%b code=%0d rdy=%b inf=%b, want 0 1 2 0 0",
               we9, load_error, error_code, cfg_if.cfg_ready, infer_enable);
    end
    idle(2);
    n_cmp++;
    if (load_error !== 1'b1 || error_code !== 2'd2) begin
      n_err++;
      $display("FAIL ooo_hold: got err=%b code=%0d, want 1 2", load_error, error_code);
    end
    pulse_start();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1 || load_error !== 1'b0 || error_code !== 2'd0) begin
      n_err++;
      $display("FAIL ooo_recover: got rdy=%b err=%b code=%0d, want 1 0 0", cfg_if.cfg_ready, load_error, error_code);
    end
  endtask

  task automatic test_bad_target();
    send(9, 0);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (we9 !== 9'd0 || load_error !== 1'b1 || error_code !== 2'd1) begin
      n_err++;
      $display("FAIL bad_target: got we=%b err=%b code=%0d, want 0 1 1", we9, load_error, error_code);
    end
    pulse_start();
  endtask

  task automatic test_overflow();
    for (int a = 0; a < 32; a++) send(0, a);
    n_cmp++;
    if (we9 !== 9'd1 || gsr_addr !== 5'd31) begin
      n_err++;
      $display("FAIL ovf_last_ok: got we=%b addr=%0d, want we=000000001 addr=31", we9, gsr_addr);
    end
    send(0, 32);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (we9 !== 9'd0 || load_error !== 1'b1 || error_code !== 2'd3) begin
      n_err++;
      $display("FAIL overflow: got we=%b err=%b code=%0d, want 0 1 3", we9, load_error, error_code);
    end
    pulse_start();
  endtask

  task automatic test_restart_collision();
    for (int a = 0; a < 5; a++) send(3, a);
    send(0, 0);
    send(0, 1);
    load_start = 1'b1;
    send(3, 5);
    load_start = 1'b0;
    n_cmp++;
    if (we9 !== 9'd0 || cfg_if.cfg_ready !== 1'b1 || load_error !== 1'b0) begin
      n_err++;
      $display("FAIL collide_drop: got we=%b rdy=%b err=%b, want 0 1 0", we9, cfg_if.cfg_ready, load_error);
    end
    send(3, 0);
    n_cmp++;
    if (we9 !== 9'b000001000 || ecg_addr !== 7'd0) begin
      n_err++;
      $display("FAIL collide_ecg_cleared: got we=%b addr=%0d, want we=000001000 addr=0", we9, ecg_addr);
    end
    send(0, 0);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (we9 !== 9'd1 || gsr_addr !== 5'd0 || load_error !== 1'b0) begin
      n_err++;
      $display("FAIL collide_gsr_cleared: got we=%b addr=%0d err=%b, want we=000000001 addr=0 err=0", we9, gsr_addr, load_error);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      if (k < 32) send(0, k);
      else send(3, k - 32);
    end
    cfg_if.cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({we9, gsr_addr, ecg_addr, eeg_addr, load_done, load_error, error_code, infer_enable, cfg_if.cfg_ready} !== 34'd0
        || {gsr_hvin, ecg_hvin, eeg_hvin} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got we=%b ea=%0d done=%b err=%b inf=%b rdy=%b, want all 0",
               we9, ecg_addr, load_done, load_error, infer_enable, cfg_if.cfg_ready);
    end
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_target = 4'd0;
    cfg_if.cfg_addr   = 7'd0;
    repeat (3) tick();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0 || we9 !== 9'd0) begin
      n_err++;
      $display("FAIL midreset_idle: got rdy=%b we=%b, want 0 0", cfg_if.cfg_ready, we9);
    end
    pulse_start();
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_start: got rdy=%b, want 1", cfg_if.cfg_ready);
    end
    send(0, 0);
    cfg_if.cfg_valid = 1'b0;
    n_cmp++;
    if (we9 !== 9'd1 || gsr_hvin !== hv_of(0, 0)) begin
      n_err++;
      $display("FAIL midreset_write: got we=%b, want 000000001 with matching data", we9);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_target = 4'd0;
    cfg_if.cfg_addr   = 7'd0;
    cfg_if.cfg_hvin   = '0;
    test_reset();
    test_full_load();
    test_done_restart();
    test_interleaved();
    test_out_of_order();
    test_bad_target();
    test_overflow();
    test_restart_collision();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hdc_sram_load_ctrl.md
Name: hdc_sram_load_ctrl

Overview:
Sequences host loading of the nine item-memory and projection hypervector SRAMs: {GSR, ECG, EEG} × {im, projm_pos, projm_neg}. It accepts a single valid/ready write stream from the FPGA-side loader and steers each beat to the correct SRAM write port. It checks that each SRAM is filled in ascending address order, exactly once per entry. It raises infer_enable only after all nine SRAMs are completely written; the top level gates the encoder's fin_ready with infer_enable.

Parameters:
GSR_NUM_CHANNEL, 32, entries per GSR SRAM
ECG_NUM_CHANNEL, 77, entries per ECG SRAM
EEG_NUM_CHANNEL, 105, entries per EEG SRAM
HV_DIMENSION, 2000, hypervector width in bits
ADDR_WIDTH, 7, host address width; must satisfy ceilLog2(max channel count) <= ADDR_WIDTH
GSR_ADDR_WIDTH / ECG_ADDR_WIDTH / EEG_ADDR_WIDTH, 5 / 7 / 7, per-modality SRAM address widths

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse; clears progress and enters LOAD
cfg_valid  in  1  host beat valid
cfg_ready  out  1  controller accepts a beat
cfg_target  in  4  target SRAM = modality*3 + kind; modality GSR=0, ECG=1, EEG=2; kind im=0, pos=1, neg=2
cfg_addr  in  ADDR_WIDTH  entry address
cfg_hvin  in  HV_DIMENSION  hypervector data
gsr_we / ecg_we / eeg_we  out  3 each  write strobes; bit0=im, bit1=projm_pos, bit2=projm_neg
gsr_addr / ecg_addr / eeg_addr  out  per-modality address width  SRAM write address
gsr_hvin / ecg_hvin / eeg_hvin  out  HV_DIMENSION each  SRAM write data
load_done  out  1  all nine SRAMs fully written
load_error  out  1  load aborted
error_code  out  2  1 = bad target, 2 = out-of-order address, 3 = overflow (SRAM already full)
infer_enable  out  1  encoder may accept features

Behaviour:
- Reset:
  - All outputs 0; state IDLE; all nine expected-address counters 0.
  - SRAM contents are not touched.
  - A reset during LOAD behaves exactly like power-on reset.
- States: IDLE, LOAD, DONE, ERROR. cfg_ready = (state==LOAD), a function of state only and never of cfg_valid.
- IDLE:
  - Waits for load_start.
  - On load_start → LOAD, counters cleared, error_code = 0.
- LOAD, beat accept (cfg_valid & cfg_ready). The target counter cnt[t] has ADDR_WIDTH+1 bits. Checks, in priority order:
  1. t > 8 → ERROR, code 1.
  2. cnt[t] == channel count of t → ERROR, code 3.
  3. cfg_addr != cnt[t] → ERROR, code 2.
  4. Otherwise, the write is valid.
- LOAD, valid write:
  - Registered address and data appear on the target modality port the next cycle, with exactly one we bit high for one cycle.
  - cnt[t] increments.
  - An erroneous beat is never written.
- Write strobes: at most one of the nine we bits is high in any cycle. Address/data outputs hold their last value when no we bit is high.
- LOAD → DONE: occurs in the cycle after the accept that fills the final incomplete SRAM. load_done and infer_enable rise in the same cycle as that final write strobe.
- Load ordering: SRAMs may be loaded interleaved in any order; only per-target address order is enforced.
- DONE:
  - load_done = infer_enable = 1; cfg_ready = 0.
  - load_start → LOAD with counters cleared; load_done and infer_enable fall the next cycle.
- ERROR:
  - load_error = 1; error_code held; cfg_ready = 0; infer_enable = 0.
  - Exits only on load_start (→ LOAD, error cleared) or rst.
- load_start asserted in LOAD:
  - Restarts the load with counters cleared.
  - A beat presented in the same cycle is discarded: no write, no check, no counter change.
- Idle cycles: cfg_valid low in LOAD stalls indefinitely without side effects.
- Total beats for a full load with defaults: 3 × (32 + 77 + 105) = 642.

Test Plan:
- Full in-order load: 642 back-to-back beats, GSR, then ECG, then EEG → 642 single-bit strobes, each one cycle after accept. Data matches beat for beat. load_done = infer_enable = 1 one cycle after beat 642; cfg_ready = 0 thereafter.
- Interleaved load: round-robin the nine targets with random cfg_valid gaps → same final state. No cycle has two we bits high.
- Out-of-order beat: ECG projm_pos (t=4) with addr 0, then addr 2 → the second beat is not written. ERROR with error_code = 2, load_error = 1. A following load_start returns to LOAD with cfg_ready = 1.
- Bad target and overflow:
  - t = 9 → error_code 1.
  - After 32 GSR im beats, a 33rd beat to t=0 with addr 32 → error_code 3, no strobe.
- Restart collisions:
  - load_start together with a valid beat mid-load → beat dropped; all counters 0.
  - load_start in DONE → infer_enable falls next cycle.
- Reset mid-load: assert rst after 100 beats → all outputs 0, state IDLE. cfg_ready stays 0 until load_start.
